// File: rtl/fpga_link_rx.sv
// Receive end of the nibble-serial inter-FPGA link: synchronizes an asynchronous
// toggle-strobed nibble stream, reassembles 17-bit flits and queues them for the ring.
module fpga_link_rx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  lnk_data_i,
    input  logic        lnk_stb_i,
    output logic        lnk_cr_o,
    output logic [16:0] out_flit_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        frame_err_o,
    output logic        ovf_err_o,
    output logic [7:0]  err_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_PUSH
    } state_t;

    logic [3:0]    data_s1_q, data_s2_q;
    logic          stb_s1_q, stb_s2_q, stb_s3_q;
    logic          nib_evt;
    logic [3:0]    nib;

    state_t        state_q, state_d;
    logic [2:0]    nib_cnt_q, nib_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [16:0]   sr_q, sr_d;
    logic          frame_err_q, frame_err_d;
    logic          ovf_err_q, ovf_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [8:0]    err_sum;
    logic          lnk_cr_q;
    logic          hdr_chk;
    logic          push;

    logic [16:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_s1_q <= '0;
            data_s2_q <= '0;
            stb_s1_q  <= 1'b0;
            stb_s2_q  <= 1'b0;
            stb_s3_q  <= 1'b0;
        end else begin
            data_s1_q <= lnk_data_i;
            data_s2_q <= data_s1_q;
            stb_s1_q  <= lnk_stb_i;
            stb_s2_q  <= stb_s1_q;
            stb_s3_q  <= stb_s2_q;
        end
    end

    assign nib_evt = stb_s2_q ^ stb_s3_q;
    assign nib     = data_s2_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && out_ready_i;

    always_comb begin
        state_d     = state_q;
        nib_cnt_d   = nib_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        sr_d        = sr_q;
        frame_err_d = 1'b0;
        ovf_err_d   = 1'b0;
        hdr_chk     = 1'b0;
        push        = 1'b0;

        case (state_q)
            S_IDLE: hdr_chk = 1'b1;
            S_BODY: begin
                if (nib_evt) begin
                    sr_d      = {sr_q[12:0], nib};
                    tmo_cnt_d = '0;
                    if (nib_cnt_q == 3'd4) begin
                        state_d   = S_PUSH;
                        nib_cnt_d = '0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 3'd1;
                    end
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                    nib_cnt_d   = '0;
                    tmo_cnt_d   = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_PUSH: begin
                // a pop in the same cycle frees the slot being written
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_err_d = 1'b1;
                end
                state_d = S_IDLE;
                hdr_chk = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // header check also runs in PUSH so back-to-back frames lose no nibble
        if (hdr_chk && nib_evt) begin
            if (nib[3:1] == 3'b101) begin
                sr_d      = {16'b0, nib[0]};
                nib_cnt_d = 3'd1;
                tmo_cnt_d = '0;
                state_d   = S_BODY;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign err_sum   = {1'b0, err_cnt_q} + {8'b0, frame_err_d} + {8'b0, ovf_err_d};
    assign err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            nib_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            sr_q        <= '0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            lnk_cr_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            nib_cnt_q   <= nib_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            sr_q        <= sr_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
            err_cnt_q   <= err_cnt_d;
            if (pop) begin
                lnk_cr_q <= ~lnk_cr_q;
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sr_q;
        end
    end

    assign out_valid_o = !empty;
    assign out_flit_o  = empty ? 17'b0 : mem_q[rd_ptr_q[AW-1:0]];
    assign lnk_cr_o    = lnk_cr_q;
    assign frame_err_o = frame_err_q;
    assign ovf_err_o   = ovf_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_fpga_link_rx.sv
// Directed and randomized checks of fpga_link_rx against a queue-based model of
// the link: frames in, flits out in order, credits per pop, error counting.
module tb_fpga_link_rx;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  lnk_data_i;
    logic        lnk_stb_i;
    logic        lnk_cr_o;
    logic [16:0] out_flit_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        frame_err_o;
    logic        ovf_err_o;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    fpga_link_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .lnk_data_i  (lnk_data_i),
        .lnk_stb_i   (lnk_stb_i),
        .lnk_cr_o    (lnk_cr_o),
        .out_flit_o  (out_flit_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .frame_err_o (frame_err_o),
        .ovf_err_o   (ovf_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [16:0] exp_q[$];
    logic        exp_cr;
    logic        prev_cr;
    int          exp_ferr, exp_ovf, seen_ferr, seen_ovf;
    int          vld_cycles, ferr_cyc, tgl_cyc, cr_toggles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one clock: consume a flit if the DUT offers it to a ready consumer, then observe
    task automatic step();
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid_o), 32'd0);
            end else begin
                chk("out_flit", 32'(out_flit_o), 32'(exp_q[0]));
                exp_q.delete(0);
                exp_cr = ~exp_cr;
            end
        end
        prev_cr = lnk_cr_o;
        @(posedge clk);
        cyc++;
        #1;
        chk("lnk_cr", 32'(lnk_cr_o), 32'(exp_cr));
        if (lnk_cr_o !== prev_cr) cr_toggles++;
        if (frame_err_o || ovf_err_o)
            chk("err_exclusive", 32'(frame_err_o & ovf_err_o), 32'd0);
        if (frame_err_o === 1'b1) begin
            seen_ferr++;
            if (ferr_cyc < 0) ferr_cyc = cyc;
        end
        if (ovf_err_o === 1'b1) seen_ovf++;
        if (out_valid_o === 1'b1) vld_cycles++;
    endtask

    task automatic do_reset(input int n);
        rst_i       = 1'b1;
        lnk_stb_i   = 1'b0;
        lnk_data_i  = 4'h0;
        out_ready_i = 1'b0;
        exp_q.delete();
        exp_cr    = 1'b0;
        exp_ferr  = 0;
        exp_ovf   = 0;
        seen_ferr = 0;
        seen_ovf  = 0;
        repeat (n) step();
        rst_i = 1'b0;
        cr_toggles = 0;
        vld_cycles = 0;
        ferr_cyc   = -1;
    endtask

    task automatic check_errs(input string tag);
        int e;
        e = exp_ferr + exp_ovf;
        chk({tag, "_frame_err_pulses"}, 32'(seen_ferr), 32'(exp_ferr));
        chk({tag, "_ovf_err_pulses"}, 32'(seen_ovf), 32'(exp_ovf));
        chk({tag, "_err_cnt"}, 32'(err_cnt_o), 32'((e > 255) ? 255 : e));
    endtask

    // setup/hold counted in clk cycles around the strobe toggle
    task automatic send_nibble(input logic [3:0] n, input int setup, input int hold,
                               input bit last, input logic [16:0] flit, input bit pp);
        lnk_data_i = n;
        repeat (setup) step();
        lnk_stb_i = ~lnk_stb_i;
        tgl_cyc   = cyc;
        if (last) begin
            if (exp_q.size() < DEPTH || pp) exp_q.push_back(flit);
            else exp_ovf++;
        end
        for (int i = 0; i < hold; i++) begin
            if (pp && i == 3) out_ready_i = 1'b1;
            step();
            if (pp && i == 3) out_ready_i = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [16:0] flit, input int setup, input int hold,
                              input bit pp);
        logic [3:0] nb;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) nb = {3'b101, flit[16]};
            else        nb = flit[4*(4-i) +: 4];
            send_nibble(nb, setup, hold, i == 4, flit, pp && i == 4);
        end
    endtask

    task automatic bad_header(input int setup, input int hold);
        logic [3:0] n;
        n = 4'($urandom_range(0, 15));
        while (n[3:1] == 3'b101) n = 4'($urandom_range(0, 15));
        send_nibble(n, setup, hold, 1'b0, 17'h0, 1'b0);
        exp_ferr++;
    endtask

    task automatic drain(input bit rnd);
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid_o) && budget < 400) begin
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            budget++;
        end
        out_ready_i = 1'b0;
        chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid_o), 32'd0);
    endtask

    logic [16:0] f6 [6];

    initial begin
        f6[0] = 17'h10011; f6[1] = 17'h00022; f6[2] = 17'h1FF33;
        f6[3] = 17'h00044; f6[4] = 17'h15555; f6[5] = 17'h06666;

        // reset state
        do_reset(3);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_flit", 32'(out_flit_o), 32'd0);
        chk("rst_lnk_cr", 32'(lnk_cr_o), 32'd0);
        chk("rst_frame_err", 32'(frame_err_o), 32'd0);
        chk("rst_ovf_err", 32'(ovf_err_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);

        // single frame, consumer always ready
        out_ready_i = 1'b1;
        send_frame(17'h1A5C3, 3, 3, 1'b0);
        repeat (6) step();
        chk("t1_consumed", 32'(exp_q.size()), 32'd0);
        chk("t1_valid_cycles", 32'(vld_cycles), 32'd1);
        chk("t1_lnk_cr", 32'(lnk_cr_o), 32'd1);
        check_errs("t1");

        // fill past depth with consumer stalled
        do_reset(2);
        for (int k = 1; k <= 5; k++) send_frame(17'(k), 3, 3, 1'b0);
        repeat (4) step();
        check_errs("t2");
        chk("t2_err_cnt_one", 32'(err_cnt_o), 32'd1);
        chk("t2_head", 32'(out_flit_o), 32'h1);
        drain(1'b0);
        chk("t2_cr_toggles", 32'(cr_toggles), 32'd4);

        // bad header then a valid frame
        do_reset(2);
        out_ready_i = 1'b1;
        send_nibble(4'h7, 3, 3, 1'b0, 17'h0, 1'b0);
        exp_ferr++;
        repeat (3) step();
        check_errs("t3a");
        send_frame(17'h0FFFF, 3, 3, 1'b0);
        repeat (6) step();
        chk("t3_consumed", 32'(exp_q.size()), 32'd0);
        check_errs("t3b");

        // inter-nibble timeout after three nibbles
        do_reset(2);
        out_ready_i = 1'b1;
        send_nibble(4'hB, 3, 3, 1'b0, 17'h0, 1'b0);
        send_nibble(4'h2, 3, 3, 1'b0, 17'h0, 1'b0);
        send_nibble(4'h3, 3, 3, 1'b0, 17'h0, 1'b0);
        begin
            int c;
            c = tgl_cyc;
            repeat (300) step();
            exp_ferr++;
            // third nibble is captured 3 edges after its toggle is driven
            chk("t4_tmo_cycle", 32'(ferr_cyc), 32'(c + 3 + TIMEOUT));
        end
        check_errs("t4a");
        chk("t4_no_partial_flit", 32'(vld_cycles), 32'd0);
        send_frame(17'h10001, 3, 3, 1'b0);
        repeat (6) step();
        chk("t4_consumed", 32'(exp_q.size()), 32'd0);
        chk("t4_valid_cycles", 32'(vld_cycles), 32'd1);
        check_errs("t4b");

        // full FIFO with a pop coinciding with the push
        do_reset(2);
        for (int k = 0; k < 4; k++) send_frame(f6[k], 3, 3, 1'b0);
        send_frame(f6[4], 3, 5, 1'b1);
        repeat (3) step();
        check_errs("t5a");
        chk("t5_head", 32'(out_flit_o), 32'(f6[1]));
        send_frame(f6[5], 3, 3, 1'b0);
        repeat (4) step();
        check_errs("t5b");
        drain(1'b0);

        // reset mid-frame with flits queued and a credit outstanding
        do_reset(2);
        bad_header(3, 3);
        for (int k = 0; k < 3; k++) send_frame(f6[k], 3, 3, 1'b0);
        repeat (3) step();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("t6_pre_lnk_cr", 32'(lnk_cr_o), 32'd1);
        chk("t6_pre_err_cnt", 32'(err_cnt_o), 32'd1);
        send_nibble(4'hA, 3, 3, 1'b0, 17'h0, 1'b0);
        send_nibble(4'h5, 3, 3, 1'b0, 17'h0, 1'b0);
        do_reset(1);
        chk("t6_out_valid", 32'(out_valid_o), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt_o), 32'd0);
        chk("t6_lnk_cr", 32'(lnk_cr_o), 32'd0);
        out_ready_i = 1'b1;
        send_frame(17'h1BEEF, 3, 3, 1'b0);
        repeat (6) step();
        chk("t6_consumed", 32'(exp_q.size()), 32'd0);
        chk("t6_valid_cycles", 32'(vld_cycles), 32'd1);
        check_errs("t6");

        // randomized bursts against the model
        do_reset(2);
        for (int r = 0; r < 8; r++) begin
            int k;
            k = $urandom_range(1, 6);
            out_ready_i = 1'b0;
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 4) == 0)
                    bad_header($urandom_range(2, 4), $urandom_range(3, 5));
                else
                    send_frame(17'($urandom), $urandom_range(2, 4), $urandom_range(3, 5), 1'b0);
            end
            repeat (4) step();
            drain(1'b1);
            check_errs("rnd");
        end

        // error counter saturation
        do_reset(2);
        repeat (260) bad_header(2, 3);
        repeat (3) step();
        check_errs("sat");
        chk("sat_err_cnt", 32'(err_cnt_o), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
